// File: rtl/pong_pkg.sv
// Shared definitions for the pong datapath: encoder value width and the
// quadrature Gray states with the transition classifier used by quad_decoder.
package pong_pkg;

  localparam int ENC_VALUE_W = 2;

  localparam logic [1:0] QD_S00 = 2'b00;
  localparam logic [1:0] QD_S01 = 2'b01;
  localparam logic [1:0] QD_S11 = 2'b11;
  localparam logic [1:0] QD_S10 = 2'b10;

  typedef enum logic [1:0] {
    QD_HOLD    = 2'd0,
    QD_FWD     = 2'd1,
    QD_REV     = 2'd2,
    QD_ILLEGAL = 2'd3
  } qd_move_e;

  // Forward order is 00->01->11->10->00; any other single-bit change is reverse.
  function automatic qd_move_e qd_classify(input logic [1:0] prev, input logic [1:0] cur);
    logic [1:0] fwd;
    case (prev)
      QD_S00:  fwd = QD_S01;
      QD_S01:  fwd = QD_S11;
      QD_S11:  fwd = QD_S10;
      default: fwd = QD_S00;
    endcase
    if (cur == prev)
      return QD_HOLD;
    else if ((cur ^ prev) == 2'b11)
      return QD_ILLEGAL;
    else if (cur == fwd)
      return QD_FWD;
    else
      return QD_REV;
  endfunction

endpackage

// File: rtl/quad_debounce.sv
// One encoder channel: SYNC_STAGES-deep synchroniser feeding a counter-based
// debounce filter. settled flags a quiet channel whose filter agrees with the pin.
module quad_debounce #(
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic pin,
  output logic filt,
  output logic settled
);

  localparam int              WARM_W    = $clog2(SYNC_STAGES + 1);
  localparam logic [WARM_W-1:0] WARM_DONE = WARM_W'(SYNC_STAGES);
  localparam logic [7:0]      CNT_LAST  = 8'(DEBOUNCE_CYCLES - 1);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   sync;
  logic [7:0]             cnt;
  logic [WARM_W-1:0]      warm;

  assign sync = sync_q[SYNC_STAGES-1];

  // Synchroniser chain: plain flops, nothing in between.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      sync_q <= '0;
    else
      sync_q <= {sync_q[SYNC_STAGES-2:0], pin};
  end

  // Debounce stage: accept a new level only after DEBOUNCE_CYCLES agreeing samples.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt  <= '0;
      filt <= 1'b0;
    end else if (sync != filt) begin
      if (cnt == CNT_LAST) begin
        filt <= sync;
        cnt  <= '0;
      end else begin
        cnt <= cnt + 8'd1;
      end
    end else begin
      cnt <= '0;
    end
  end

  // The chain still holds its reset zeros for SYNC_STAGES edges; until they are
  // flushed a pin resting high would look settled at 0 and prime too early.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      warm <= '0;
    else if (warm != WARM_DONE)
      warm <= warm + 1'b1;
  end

  assign settled = (warm == WARM_DONE) && (sync == filt) && (cnt == 8'd0);

endmodule

// File: rtl/quad_decoder.sv
// Rotary encoder front end: debounced A/B channels decoded into a 2-bit signed
// wrapping position with step, direction and illegal-transition pulses.
module quad_decoder
  import pong_pkg::*;
#(
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          enc_a,
  input  logic                          enc_b,
  output logic signed [ENC_VALUE_W-1:0] value_o,
  output logic                          step_o,
  output logic                          dir_o,
  output logic                          error_o
);

  logic       filt_a;
  logic       filt_b;
  logic       settled_a;
  logic       settled_b;
  logic       primed;
  logic [1:0] cur;
  logic [1:0] prev;

  function automatic logic signed [ENC_VALUE_W-1:0] wrap_step(
    input logic signed [ENC_VALUE_W-1:0] v,
    input logic                          up
  );
    return up ? (v + 2'sd1) : (v - 2'sd1);
  endfunction

  quad_debounce #(
    .SYNC_STAGES    (SYNC_STAGES),
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_deb_a (
    .clk    (clk),
    .reset  (reset),
    .pin    (enc_a),
    .filt   (filt_a),
    .settled(settled_a)
  );

  quad_debounce #(
    .SYNC_STAGES    (SYNC_STAGES),
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_deb_b (
    .clk    (clk),
    .reset  (reset),
    .pin    (enc_b),
    .filt   (filt_b),
    .settled(settled_b)
  );

  assign cur = {filt_a, filt_b};

  // Decode stage: prev always tracks cur; counting only once both channels have settled.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      prev    <= QD_S00;
      primed  <= 1'b0;
      value_o <= '0;
      step_o  <= 1'b0;
      dir_o   <= 1'b0;
      error_o <= 1'b0;
    end else begin
      prev    <= cur;
      step_o  <= 1'b0;
      error_o <= 1'b0;
      if (!primed) begin
        primed <= settled_a && settled_b;
      end else begin
        case (qd_classify(prev, cur))
          QD_FWD: begin
            value_o <= wrap_step(value_o, 1'b1);
            step_o  <= 1'b1;
            dir_o   <= 1'b1;
          end
          QD_REV: begin
            value_o <= wrap_step(value_o, 1'b0);
            step_o  <= 1'b1;
            dir_o   <= 1'b0;
          end
          QD_ILLEGAL: error_o <= 1'b1;
          default: ;
        endcase
      end
    end
  end

endmodule
